// File: rtl/scancode_gen.sv
// scancode_gen: 8x5 key matrix scanner emitting PS/2 set-2 make/break bytes.
// Scans one row at a time, detects key changes, hands bytes out on a strobe.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - synchronous active-high reset
//   enable - allows the scan to advance to the next row
//   row    - active-low row select (8'hFF while idle)
//   col    - active-low column sense from the matrix
//   ready  - consumer can take a byte this cycle
//   strb   - single-cycle byte strobe (only while ready=1)
//   code   - set-2 byte, valid while strb=1
module scancode_gen #(
  parameter int SETTLE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] row,
  input  logic [4:0] col,
  input  logic       ready,
  output logic       strb,
  output logic [7:0] code
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_SAMPLE,
    S_CHECK,
    S_PREFIX,
    S_GAP1,
    S_EMIT,
    S_GAP2,
    S_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      snap_q, snap_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      code_q, code_d;
  logic [7:0]      row_q, row_d;
  logic [7:0][4:0] stored_q, stored_d;
  logic [4:0]      diff;
  logic [2:0]      low;

  function automatic logic [7:0] row_sel(input logic [2:0] i);
    return ~(8'h01 << i);
  endfunction

  function automatic logic [7:0] key_code(
    input logic [2:0] r,
    input logic [2:0] b
  );
    logic [7:0] c;
    c = 8'h00;
    case ({r, b})
      6'o00: c = 8'h12;
      6'o01: c = 8'h1A;
      6'o02: c = 8'h22;
      6'o03: c = 8'h21;
      6'o04: c = 8'h2A;
      6'o10: c = 8'h1C;
      6'o11: c = 8'h1B;
      6'o12: c = 8'h23;
      6'o13: c = 8'h2B;
      6'o14: c = 8'h34;
      6'o20: c = 8'h15;
      6'o21: c = 8'h1D;
      6'o22: c = 8'h24;
      6'o23: c = 8'h2D;
      6'o24: c = 8'h2C;
      6'o30: c = 8'h16;
      6'o31: c = 8'h1E;
      6'o32: c = 8'h26;
      6'o33: c = 8'h25;
      6'o34: c = 8'h2E;
      6'o40: c = 8'h45;
      6'o41: c = 8'h46;
      6'o42: c = 8'h3E;
      6'o43: c = 8'h3D;
      6'o44: c = 8'h36;
      6'o50: c = 8'h4D;
      6'o51: c = 8'h44;
      6'o52: c = 8'h43;
      6'o53: c = 8'h3C;
      6'o54: c = 8'h35;
      6'o60: c = 8'h5A;
      6'o61: c = 8'h4B;
      6'o62: c = 8'h42;
      6'o63: c = 8'h3B;
      6'o64: c = 8'h33;
      6'o70: c = 8'h29;
      6'o71: c = 8'h14;
      6'o72: c = 8'h3A;
      6'o73: c = 8'h31;
      6'o74: c = 8'h32;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    bit_d    = bit_q;
    code_d   = code_q;
    row_d    = row_q;
    stored_d = stored_q;
    strb     = 1'b0;

    diff = snap_q ^ stored_q[idx_q];
    low  = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (diff[i]) low = 3'(i);
    end

    unique case (state_q)
      S_SETTLE: begin
        row_d = row_sel(idx_q);
        // Only count cycles in which the row is
        // actually driven (not the idle 8'hFF).
        if (row_q != 8'hFF) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_SAMPLE: begin
        snap_d  = col;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (diff == 5'd0) begin
          state_d = S_NEXT;
        end else begin
          bit_d = low;
          if (snap_q[low]) begin
            code_d  = 8'hF0;
            state_d = S_PREFIX;
          end else begin
            code_d  = key_code(idx_q, low);
            state_d = S_EMIT;
          end
        end
      end
      S_PREFIX: begin
        if (ready) begin
          strb    = 1'b1;
          state_d = S_GAP1;
        end
      end
      S_GAP1: begin
        code_d  = key_code(idx_q, bit_q);
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (ready) begin
          strb = 1'b1;
          stored_d[idx_q][bit_q] = snap_q[bit_q];
          state_d = S_GAP2;
        end
      end
      S_GAP2: begin
        state_d = S_CHECK;
      end
      S_NEXT: begin
        if (enable) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          row_d   = row_sel(idx_q + 3'd1);
          state_d = S_SETTLE;
        end else begin
          row_d = 8'hFF;
        end
      end
    endcase

    // A pending byte must not escape while reset is held.
    if (reset) strb = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_SETTLE;
      idx_q    <= 3'd0;
      cnt_q    <= 8'd0;
      snap_q   <= 5'h1F;
      bit_q    <= 3'd0;
      code_q   <= 8'h00;
      row_q    <= 8'hFF;
      stored_q <= '1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      row_q    <= row_d;
      stored_q <= stored_d;
    end
  end

  assign row  = row_q;
  assign code = code_q;

endmodule

// File: tb/tb_scancode_gen.sv
// tb_scancode_gen: directed and random checks of scancode_gen.
// A key matrix model drives col; a make/break model predicts the bytes.
module tb_scancode_gen;

  localparam int SETTLE = 4;
  localparam int SCAN   = 8 * (SETTLE + 3);

  localparam logic [7:0] MAP [8][5] = '{
    '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
  };

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] row;
  logic [4:0] col;
  logic       ready;
  logic       strb;
  logic [7:0] code;

  // keys: 1 = physically pressed; mst: what the host has been told
  logic [4:0] keys [8];
  logic [4:0] mst  [8];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       prev_strb = 1'b0;
  logic [7:0] last_row = 8'hFF;
  logic [7:0] obs_q [$];
  logic [7:0] exp_q [$];
  int         obs_t [$];

  scancode_gen #(.SETTLE(SETTLE)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .row    (row),
    .col    (col),
    .ready  (ready),
    .strb   (strb),
    .code   (code)
  );

  always #5 clock = ~clock;

  always_comb begin
    col = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      if (!row[r]) col = col & ~keys[r];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (row != 8'hFF) last_row = row;
    if (strb === 1'b1) begin
      chk("strb_ready", 32'(ready), 32'd1);
      chk("strb_spacing", 32'(prev_strb), 32'd0);
      obs_q.push_back(code);
      obs_t.push_back(cyc);
    end
    prev_strb = strb;
  end

  task automatic plan(input int start);
    for (int k = 1; k <= 8; k++) begin
      int r;
      r = (start + k) % 8;
      for (int b = 0; b < 5; b++) begin
        if (keys[r][b] != mst[r][b]) begin
          if (!keys[r][b]) exp_q.push_back(8'hF0);
          exp_q.push_back(MAP[r][b]);
          mst[r][b] = keys[r][b];
        end
      end
    end
  endtask

  task automatic run(input int n, input bit rnd);
    enable = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ready = 1'b1;
  endtask

  task automatic pause(output int idx);
    bit ok;
    ok     = 1'b0;
    enable = 1'b0;
    ready  = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clock);
      if (row == 8'hFF) ok = 1'b1;
    end
    chk("pause_reached", 32'(ok), 32'd1);
    idx = 0;
    for (int r = 0; r < 8; r++) begin
      if (!last_row[r]) idx = r;
    end
  endtask

  task automatic cmp(input string tag, input bit strict);
    int d;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    if (strict) begin
      for (int i = 0; i + 1 < obs_q.size(); i++) begin
        d = obs_t[i+1] - obs_t[i];
        if (obs_q[i] == 8'hF0) chk({tag, "_gap1"}, 32'(d), 32'd2);
        else chk({tag, "_gap"}, 32'(d >= 2), 32'd1);
      end
    end
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx;
    int         k;
    int         len;
    int         n;
    bit         ok;
    logic [7:0] cur;
    logic [7:0] want_row;

    for (int r = 0; r < 8; r++) begin
      keys[r] = 5'h00;
      mst[r]  = 5'h00;
    end
    reset  = 1'b1;
    enable = 1'b0;
    ready  = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_row", 32'(row), 32'hFF);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_code", 32'(code), 32'h00);

    // Idle scanning: row sequence and dwell time.
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock);
    chk("first_row", 32'(row), 32'hFE);
    cur = row;
    len = 1;
    k   = 0;
    for (int i = 0; i < 400 && k < 24; i++) begin
      @(negedge clock);
      if (row === cur) begin
        len++;
      end else begin
        chk("row_len", 32'(len), 32'(SETTLE + 3));
        k++;
        want_row = ~(8'h01 << (k % 8));
        chk("row_val", 32'(row), 32'(want_row));
        cur = row;
        len = 1;
      end
    end
    chk("scan_count", 32'(k), 32'd24);
    pause(idx);
    cmp("idle", 1'b1);

    // Z pressed, then idle scans.
    keys[0][1] = 1'b1;
    plan(idx);
    run(2 * SCAN + 40, 1'b0);
    pause(idx);
    cmp("z_make", 1'b1);
    plan(idx);
    run(2 * SCAN, 1'b0);
    pause(idx);
    cmp("z_hold", 1'b1);

    // Z released: F0, one idle cycle, 1A.
    keys[0][1] = 1'b0;
    plan(idx);
    run(2 * SCAN + 40, 1'b0);
    pause(idx);
    cmp("z_break", 1'b1);

    // SPACE and B in one row.
    keys[7][0] = 1'b1;
    keys[7][4] = 1'b1;
    plan(idx);
    run(2 * SCAN + 40, 1'b0);
    pause(idx);
    cmp("space_b", 1'b1);

    // A make held off by ready=0.
    keys[1][0] = 1'b1;
    plan(idx);
    ready  = 1'b0;
    enable = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (code == 8'h1C) ok = 1'b1;
    end
    chk("a_pending", 32'(ok), 32'd1);
    repeat (10) begin
      @(negedge clock);
      chk("a_hold_strb", 32'(strb), 32'd0);
      chk("a_hold_code", 32'(code), 32'h1C);
    end
    @(posedge clock);
    #1 ready = 1'b1;
    @(negedge clock);
    chk("a_release_strb", 32'(strb), 32'd1);
    chk("a_release_code", 32'(code), 32'h1C);
    run(2 * SCAN, 1'b0);
    pause(idx);
    cmp("a_make", 1'b0);

    // Q make, then reset during its break prefix.
    keys[2][0] = 1'b1;
    plan(idx);
    run(2 * SCAN + 40, 1'b0);
    pause(idx);
    cmp("q_make", 1'b1);
    keys[2][0] = 1'b0;
    ready  = 1'b0;
    enable = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (code == 8'hF0) ok = 1'b1;
    end
    chk("q_prefix", 32'(ok), 32'd1);
    chk("q_prefix_strb", 32'(strb), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_rst_row", 32'(row), 32'hFF);
    chk("mid_rst_code", 32'(code), 32'h00);
    chk("mid_rst_strb", 32'(strb), 32'd0);
    chk("mid_rst_nobyte", 32'(obs_q.size()), 32'd0);
    keys[2][0] = 1'b1;
    for (int r = 0; r < 8; r++) mst[r] = 5'h00;
    exp_q.delete();
    reset = 1'b0;
    plan(7);
    run(2 * SCAN + 80, 1'b0);
    pause(idx);
    cmp("q_after_rst", 1'b1);

    // Random key changes with random back-pressure.
    for (int round = 0; round < 12; round++) begin
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        int r;
        int b;
        r = $urandom_range(0, 7);
        b = $urandom_range(0, 4);
        keys[r][b] = ~keys[r][b];
      end
      plan(idx);
      run(3 * SCAN + 60, 1'b1);
      pause(idx);
      cmp("rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
